// File: rtl/shift_cmd_sequencer_if.sv
// Command channel into the shift-register sequencer: one command per
// valid/ready handshake. The master drives the command fields and the slave
// (the sequencer) answers with ready.
interface shift_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Command-driven controller for a 4-bit universal shift register.
// A command (load, shift right N, shift left N, hold N) is latched on the
// handshake and replayed onto the register's mode/serial/parallel inputs for
// exactly the commanded number of enabled cycles, followed by one DONE cycle.
// Everything freezes while ena is low, matching the register's own enable,
// so the number of applied operations is exact.
module shift_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  shift_cmd_sequencer_if.slave cmd,
  output logic [1:0]           sr_mode,
  output logic                 sr_sin_left,
  output logic                 sr_sin_right,
  output logic [WIDTH-1:0]     sr_pdata,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SR    = 2'b01;
  localparam logic [1:0] OP_SL    = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;

  // Handshake: ready only in IDLE with the register enabled and out of reset.
  always_comb begin
    cmd.cmd_ready = (state == IDLE) && ena && !rst;
    accept        = cmd.cmd_valid && cmd.cmd_ready;
  end

  // Next-state selection; a zero-count non-load command skips straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_LOAD) begin
            state_next = LOAD;
          end else if (cmd.cmd_count != '0) begin
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      LOAD: state_next = DONE;
      RUN: begin
        if (remaining <= CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; advances only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Latched command fields and the remaining-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      op_q      <= OP_HOLD;
      fill_q    <= 1'b0;
      data_q    <= '0;
    end else if (ena) begin
      if (accept) begin
        remaining <= cmd.cmd_count;
        op_q      <= cmd.cmd_op;
        fill_q    <= cmd.cmd_fill;
        data_q    <= cmd.cmd_data;
      end else if (state == RUN) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  // Register-facing outputs decode from state and latched fields only.
  always_comb begin
    sr_mode      = OP_HOLD;
    sr_sin_left  = 1'b0;
    sr_sin_right = 1'b0;
    sr_pdata     = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      LOAD: begin
        busy     = 1'b1;
        sr_mode  = OP_LOAD;
        sr_pdata = data_q;
      end
      RUN: begin
        busy         = 1'b1;
        sr_mode      = op_q;
        sr_sin_left  = (op_q == OP_SR) ? fill_q : 1'b0;
        sr_sin_right = (op_q == OP_SL) ? fill_q : 1'b0;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: directed scenarios plus randomized commands,
// checked against a transaction-level model that expands each accepted
// command into the sequence of register-facing frames it should produce.
module tb_shift_cmd_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [1:0]       sr_mode;
  logic             sr_sin_left;
  logic             sr_sin_right;
  logic [WIDTH-1:0] sr_pdata;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  shift_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_bus ();

  shift_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .cmd          (cmd_bus.slave),
    .sr_mode      (sr_mode),
    .sr_sin_left  (sr_sin_left),
    .sr_sin_right (sr_sin_right),
    .sr_pdata     (sr_pdata),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Frame layout: {busy, done, mode[1:0], sin_left, sin_right, pdata[3:0]}
  logic [9:0] frame_q[$];
  logic [9:0] model_f;
  logic [3:0] q_ref = 4'b0000;
  logic [3:0] q_dut = 4'b0000;

  // Behaviour of the downstream 4-bit universal shift register.
  function automatic logic [3:0] apply_mode(input logic [3:0] q, input logic [1:0] mode,
                                            input logic sl, input logic sr, input logic [3:0] pd);
    case (mode)
      2'b01:   return {sl, q[3:1]};
      2'b10:   return {q[2:0], sr};
      2'b11:   return pd;
      default: return q;
    endcase
  endfunction

  // Register driven by the DUT outputs, gated by the same enable.
  always @(posedge clk) begin
    if (ena) q_dut <= apply_mode(q_dut, sr_mode, sr_sin_left, sr_sin_right, sr_pdata);
  end

  // Reference model: accept when idle, expand command into frames, replay one per enabled edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q.delete();
    end else if (ena) begin
      if (frame_q.size() == 0) begin
        if (cmd_bus.cmd_valid) begin
          if (cmd_bus.cmd_op == 2'b11) begin
            frame_q.push_back({1'b1, 1'b0, 2'b11, 1'b0, 1'b0, cmd_bus.cmd_data});
          end else begin
            for (int i = 0; i < int'(cmd_bus.cmd_count); i++)
              frame_q.push_back({1'b1, 1'b0, cmd_bus.cmd_op,
                                 (cmd_bus.cmd_op == 2'b01) ? cmd_bus.cmd_fill : 1'b0,
                                 (cmd_bus.cmd_op == 2'b10) ? cmd_bus.cmd_fill : 1'b0, 4'b0000});
          end
          frame_q.push_back({1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'b0000});
        end
      end else begin
        model_f = frame_q.pop_front();
        q_ref = apply_mode(q_ref, model_f[7:6], model_f[5], model_f[4], model_f[3:0]);
      end
    end
  end

  function automatic logic [10:0] exp_vec();
    logic       rdy;
    logic [9:0] f;
    rdy = (frame_q.size() == 0) && ena && !rst;
    f   = (frame_q.size() != 0) ? frame_q[0] : 10'b0;
    return {rdy, f};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {cmd_bus.cmd_ready, busy, done, sr_mode, sr_sin_left, sr_sin_right, sr_pdata};
  endfunction

  // One cycle: inputs change 1ns after the rising edge, outputs observed on the falling edge.
  task automatic drive_cycle(input logic r, input logic e, input logic v, input logic [1:0] op,
                             input logic [3:0] cnt, input logic f, input logic [3:0] d);
    @(posedge clk);
    #1;
    rst               = r;
    ena               = e;
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_count = cnt;
    cmd_bus.cmd_fill  = f;
    cmd_bus.cmd_data  = d;
    @(negedge clk);
  endtask

  int         st_nonhold, st_done, st_busy, st_diffs;
  bit         st_finished;
  logic [10:0] st_obs, st_exp;

  // Issues one command, optionally stalling ena or resetting mid-run, and gathers observations.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic f,
                         input logic [3:0] d, input int stall_at, input int stall_len,
                         input int rst_at);
    logic v = 1'b1;
    logic e, r;
    bit   accepted = 0;
    int   c_after = 0;
    int   rst_cycles = 0;
    st_nonhold = 0; st_done = 0; st_busy = 0; st_diffs = 0; st_finished = 0;
    st_obs = '0; st_exp = '0;
    for (int c = 0; c < 64 && !st_finished; c++) begin
      e = 1'b1;
      if (accepted && stall_len > 0 && c_after >= stall_at && c_after < stall_at + stall_len) e = 1'b0;
      r = 1'b0;
      if (rst_at > 0 && st_nonhold >= rst_at && rst_cycles < 2) begin
        r = 1'b1;
        rst_cycles++;
      end
      drive_cycle(r, e, v, op, cnt, f, d);
      if (obs_vec() !== exp_vec()) begin
        if (st_diffs == 0) begin st_obs = obs_vec(); st_exp = exp_vec(); end
        st_diffs++;
      end
      if (e && sr_mode != 2'b00) st_nonhold++;
      if (e && done) st_done++;
      if (e && busy) st_busy++;
      if (v && cmd_bus.cmd_ready) begin
        v = 1'b0; accepted = 1; c_after = 0;
      end else if (accepted) begin
        c_after++;
      end
      if (accepted && !busy && !r && (st_done > 0 || rst_cycles > 0)) st_finished = 1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      n_checks++;
      if (obs_vec() !== 11'b0) begin
        n_errors++;
        $display("[TB] FAIL reset_outputs cyc %0d: got %b expected %b", i, obs_vec(), 11'b0);
      end
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("[TB] FAIL reset_release_idle: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_shift_right();
    run_cmd(2'b01, 4'd3, 1'b1, 4'd0, 0, 0, 0);
    n_checks++;
    if (st_finished !== 1'b1) begin n_errors++; $display("[TB] FAIL shift_right_timeout: got %0d expected 1", st_finished); end
    n_checks++;
    if (st_diffs !== 0) begin n_errors++; $display("[TB] FAIL shift_right_frames: %0d diffs, first got %b expected %b", st_diffs, st_obs, st_exp); end
    n_checks++;
    if (st_nonhold !== 3) begin n_errors++; $display("[TB] FAIL shift_right_cycles: got %0d expected 3", st_nonhold); end
    n_checks++;
    if (st_done !== 1) begin n_errors++; $display("[TB] FAIL shift_right_done: got %0d expected 1", st_done); end
    n_checks++;
    if (q_dut !== 4'b1110) begin n_errors++; $display("[TB] FAIL shift_right_q: got %b expected 1110", q_dut); end
  endtask

  task automatic test_load_shift();
    run_cmd(2'b11, 4'd0, 1'b0, 4'b1010, 0, 0, 0);
    n_checks++;
    if (st_diffs !== 0 || st_finished !== 1'b1) begin n_errors++; $display("[TB] FAIL load_frames: %0d diffs fin %0d, first got %b expected %b", st_diffs, st_finished, st_obs, st_exp); end
    n_checks++;
    if (st_nonhold !== 1) begin n_errors++; $display("[TB] FAIL load_cycles: got %0d expected 1", st_nonhold); end
    n_checks++;
    if (q_dut !== 4'b1010) begin n_errors++; $display("[TB] FAIL load_q: got %b expected 1010", q_dut); end
    run_cmd(2'b10, 4'd2, 1'b0, 4'd0, 0, 0, 0);
    n_checks++;
    if (st_diffs !== 0 || st_finished !== 1'b1) begin n_errors++; $display("[TB] FAIL shift_left_frames: %0d diffs fin %0d, first got %b expected %b", st_diffs, st_finished, st_obs, st_exp); end
    n_checks++;
    if (q_dut !== 4'b1000) begin n_errors++; $display("[TB] FAIL shift_left_q: got %b expected 1000", q_dut); end
  endtask

  task automatic test_zero_count();
    run_cmd(2'b10, 4'd0, 1'b1, 4'd0, 0, 0, 0);
    n_checks++;
    if (st_diffs !== 0 || st_finished !== 1'b1) begin n_errors++; $display("[TB] FAIL zero_frames: %0d diffs fin %0d, first got %b expected %b", st_diffs, st_finished, st_obs, st_exp); end
    n_checks++;
    if (st_nonhold !== 0) begin n_errors++; $display("[TB] FAIL zero_nonhold: got %0d expected 0", st_nonhold); end
    n_checks++;
    if (st_busy !== 1) begin n_errors++; $display("[TB] FAIL zero_busy: got %0d expected 1", st_busy); end
    n_checks++;
    if (st_done !== 1) begin n_errors++; $display("[TB] FAIL zero_done: got %0d expected 1", st_done); end
  endtask

  task automatic test_enable_stall();
    run_cmd(2'b01, 4'd4, 1'($urandom_range(0, 1)), 4'd0, 2, 3, 0);
    n_checks++;
    if (st_diffs !== 0 || st_finished !== 1'b1) begin n_errors++; $display("[TB] FAIL stall_frames: %0d diffs fin %0d, first got %b expected %b", st_diffs, st_finished, st_obs, st_exp); end
    n_checks++;
    if (st_nonhold !== 4) begin n_errors++; $display("[TB] FAIL stall_cycles: got %0d expected 4", st_nonhold); end
    n_checks++;
    if (st_done !== 1) begin n_errors++; $display("[TB] FAIL stall_done: got %0d expected 1", st_done); end
    n_checks++;
    if (q_dut !== q_ref) begin n_errors++; $display("[TB] FAIL stall_q: got %b expected %b", q_dut, q_ref); end
  endtask

  task automatic test_back_to_back();
    logic       v = 1'b1;
    logic [1:0] op = 2'b01;
    logic [3:0] cnt = 4'd15;
    logic       f = 1'($urandom_range(0, 1));
    logic [3:0] d = 4'd0;
    int a1 = -1, a2 = -1, rdy_busy = 0;
    bit fin = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      drive_cycle(1'b0, 1'b1, v, op, cnt, f, d);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL b2b_frame cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
      end
      if (cmd_bus.cmd_ready && busy) rdy_busy++;
      if (v && cmd_bus.cmd_ready) begin
        if (a1 < 0) begin a1 = c; op = 2'b11; cnt = 4'd0; d = 4'b0101; end
        else begin a2 = c; v = 1'b0; end
      end
      if (a2 >= 0 && c > a2 && !busy) fin = 1;
    end
    n_checks++;
    if (fin !== 1'b1) begin n_errors++; $display("[TB] FAIL b2b_timeout: got %0d expected 1", fin); end
    n_checks++;
    if (a2 - a1 !== 17) begin n_errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 17", a2 - a1); end
    n_checks++;
    if (rdy_busy !== 0) begin n_errors++; $display("[TB] FAIL b2b_ready_busy: got %0d expected 0", rdy_busy); end
    n_checks++;
    if (q_dut !== 4'b0101) begin n_errors++; $display("[TB] FAIL b2b_q: got %b expected 0101", q_dut); end
  endtask

  task automatic test_reset_mid_run();
    run_cmd(2'b11, 4'd0, 1'b0, 4'b0000, 0, 0, 0);
    run_cmd(2'b01, 4'd5, 1'b1, 4'd0, 0, 0, 2);
    n_checks++;
    if (st_diffs !== 0 || st_finished !== 1'b1) begin n_errors++; $display("[TB] FAIL rstmid_frames: %0d diffs fin %0d, first got %b expected %b", st_diffs, st_finished, st_obs, st_exp); end
    n_checks++;
    if (st_done !== 0) begin n_errors++; $display("[TB] FAIL rstmid_done: got %0d expected 0", st_done); end
    n_checks++;
    if (q_dut !== 4'b1100) begin n_errors++; $display("[TB] FAIL rstmid_q: got %b expected 1100", q_dut); end
    run_cmd(2'b10, 4'd2, 1'b1, 4'd0, 0, 0, 0);
    n_checks++;
    if (st_diffs !== 0 || st_done !== 1) begin n_errors++; $display("[TB] FAIL rstmid_next: %0d diffs done %0d, first got %b expected %b", st_diffs, st_done, st_obs, st_exp); end
    n_checks++;
    if (q_dut !== 4'b0011) begin n_errors++; $display("[TB] FAIL rstmid_next_q: got %b expected 0011", q_dut); end
  endtask

  task automatic test_random();
    logic       v = 1'b0;
    logic       e;
    logic [1:0] op = 2'b00;
    logic [3:0] cnt = 4'd0;
    logic       f = 1'b0;
    logic [3:0] d = 4'd0;
    for (int c = 0; c < 640; c++) begin
      if (c >= 600) begin
        v = 1'b0; e = 1'b1;
      end else begin
        if (!v && $urandom_range(0, 2) == 0) begin
          v   = 1'b1;
          op  = 2'($urandom_range(0, 3));
          cnt = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
          f   = 1'($urandom_range(0, 1));
          d   = 4'($urandom_range(0, 15));
        end
        e = ($urandom_range(0, 4) != 0);
      end
      drive_cycle(1'b0, e, v, op, cnt, f, d);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL random_frame cyc %0d: got %b expected %b", c, obs_vec(), exp_vec());
      end
      n_checks++;
      if (q_dut !== q_ref) begin
        n_errors++;
        $display("[TB] FAIL random_q cyc %0d: got %b expected %b", c, q_dut, q_ref);
      end
      if (v && cmd_bus.cmd_ready) v = 1'b0;
    end
  endtask

  // Hard time limit so a stuck run still ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst               = 1'b1;
    ena               = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'b00;
    cmd_bus.cmd_count = '0;
    cmd_bus.cmd_fill  = 1'b0;
    cmd_bus.cmd_data  = '0;
    $display("[TB] starting shift_cmd_sequencer bench");
    test_reset();
    test_shift_right();
    test_load_shift();
    test_zero_count();
    test_enable_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
